// File: rtl/z_bin2bcd_seq_if.sv
// z_bin2bcd_seq_if: start/busy/done handshake and result bus of the binary-to-BCD converter.
// Carries the extra blank vector when BIN2BCD_BLANK_EN is defined.
interface z_bin2bcd_seq_if #(
    parameter int W      = 30,
    parameter int DIGITS = 10
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
    modport master (output start, bin, input busy, done, bcd, blank);
    modport slave  (input start, bin, output busy, done, bcd, blank);
`else
    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/z_bin2bcd_seq.sv
// z_bin2bcd_seq: sequential double-dabble converter, one shift per clock, result held until next DONE.
// Optional leading-zero blanking output enabled by BIN2BCD_BLANK_EN.
module z_bin2bcd_seq #(
    parameter int W      = 30,
    parameter int DIGITS = 10
) (
    input logic             clk,
    input logic             rst,
    z_bin2bcd_seq_if.slave  bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    function automatic logic fits();
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < DIGITS; i++) p = p * 128'd10;
        return p > ((128'd1 << W) - 128'd1);
    endfunction

    generate
        if (!fits()) begin : g_bad_digits
            $error("z_bin2bcd_seq: DIGITS too small for W");
        end
    endgenerate

    logic [1:0]          state;
    logic [W-1:0]        binreg;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] nxt;
    logic [4*DIGITS-1:0] bcd_r;
    logic [CW-1:0]       cnt;

    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    end

    // accumulator value after this cycle's add-3 and shift; also the final result on the last shift
    assign nxt = {adj[4*DIGITS-2:0], binreg[W-1]};

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_n;
    logic [DIGITS-1:0] blank_r;
    logic              run;

    // blank digit i while it and every digit above it are zero; digit 0 always shows
    always_comb begin
        blank_n = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            run = run & (nxt[4*i +: 4] == 4'd0);
            blank_n[i] = run;
        end
    end

    assign bus.blank = blank_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            binreg <= '0;
            acc    <= '0;
            cnt    <= '0;
            bcd_r  <= '0;
`ifdef BIN2BCD_BLANK_EN
            blank_r <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    binreg <= bus.bin;
                    acc    <= '0;
                    cnt    <= CW'(W);
                    state  <= SHIFT;
                end
                SHIFT: begin
                    acc    <= nxt;
                    binreg <= binreg << 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                        bcd_r <= nxt;
`ifdef BIN2BCD_BLANK_EN
                        blank_r <= blank_n;
`endif
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.bcd  = bcd_r;
endmodule
